// File: rtl/aux_snapshot_controller.sv
// aux_snapshot_controller: once per frame, copies CPU state plus instruction/data memory windows into aux memory.
// Optional feature macro AUX_SNAPSHOT_HOLD_EN adds hold_in, which blocks new snapshots while high.
module aux_snapshot_controller #(
    parameter int DATA_WIDTH           = 16,
    parameter int MEMORY_ADDRESS_WIDTH = 11,
    parameter int AUX_ADDRESS_WIDTH    = 5,
    parameter int CPU_ELEMENTS         = 10,
    parameter int MEMORY_ELEMENTS      = 10
) (
    input  logic                            clock_in,
    input  logic                            reset_in,
    input  logic                            frame_start_in,
`ifdef AUX_SNAPSHOT_HOLD_EN
    input  logic                            hold_in,
`endif
    output logic [3:0]                      cpu_select_out,
    input  logic [DATA_WIDTH-1:0]           cpu_data_in,
    output logic                            mem_req_out,
    input  logic                            mem_grant_in,
    output logic                            mem_select_out,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_raddress_out,
    input  logic [DATA_WIDTH-1:0]           mem_data_in,
    output logic                            aux_we_out,
    output logic [AUX_ADDRESS_WIDTH-1:0]    aux_waddress_out,
    output logic [DATA_WIDTH-1:0]           aux_wdata_out,
    output logic                            busy_out,
    output logic                            done_out
);
    localparam int FINAL = 2**MEMORY_ADDRESS_WIDTH - 1;
    localparam logic [3:0] S_IDLE = 4'd0, S_CPU = 4'd1, S_CALC = 4'd2,
                           S_IREQ = 4'd3, S_IWAIT = 4'd4, S_IWR = 4'd5,
                           S_DREQ = 4'd6, S_DWAIT = 4'd7, S_DWR = 4'd8,
                           S_DONE = 4'd9;

    logic [3:0]                      state_q, state_d, k_q, k_d;
    logic [DATA_WIDTH-1:0]           pc_q, pc_d, daddr_q, daddr_d, word_q, word_d;
    logic [MEMORY_ADDRESS_WIDTH-1:0] ibase_q, ibase_d, dbase_q, dbase_d, base;
    logic                            start, copy, ireq, dreq, iwr, dwr, last_word;

    // Window starts four words before the address, clamped so the whole window stays inside memory.
    function automatic logic [MEMORY_ADDRESS_WIDTH-1:0] window_base(input logic [DATA_WIDTH-1:0] a);
        return (a < DATA_WIDTH'(5)) ? '0 :
               (a > DATA_WIDTH'(FINAL - 5)) ? MEMORY_ADDRESS_WIDTH'(FINAL - 9) :
               MEMORY_ADDRESS_WIDTH'(a - DATA_WIDTH'(4));
    endfunction

`ifdef AUX_SNAPSHOT_HOLD_EN
    assign start = frame_start_in && !hold_in;
`else
    assign start = frame_start_in;
`endif

    assign copy      = state_q == S_CPU;
    assign ireq      = state_q == S_IREQ;
    assign dreq      = state_q == S_DREQ;
    assign iwr       = state_q == S_IWR;
    assign dwr       = state_q == S_DWR;
    assign last_word = k_q == 4'(MEMORY_ELEMENTS - 1);
    assign base      = dreq ? dbase_q : ibase_q;

    // Sequencer next state: CPU copy, base calculation, then request/wait/write per memory word.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        pc_d    = pc_q;
        daddr_d = daddr_q;
        ibase_d = ibase_q;
        dbase_d = dbase_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CPU;
                k_d     = '0;
            end
            S_CPU: begin
                pc_d    = (k_q == 4'd0) ? cpu_data_in : pc_q;
                daddr_d = (k_q == 4'd2) ? cpu_data_in : daddr_q;
                k_d     = (k_q == 4'(CPU_ELEMENTS - 1)) ? '0 : k_q + 4'd1;
                state_d = (k_q == 4'(CPU_ELEMENTS - 1)) ? S_CALC : S_CPU;
            end
            S_CALC: begin
                ibase_d = window_base(pc_q);
                dbase_d = window_base(daddr_q);
                state_d = S_IREQ;
            end
            S_IREQ, S_DREQ: state_d = mem_grant_in ? state_q + 4'd1 : state_q;
            S_IWAIT, S_DWAIT: begin
                word_d  = mem_data_in;
                state_d = state_q + 4'd1;
            end
            S_IWR, S_DWR: begin
                k_d     = last_word ? '0 : k_q + 4'd1;
                state_d = last_word ? state_q + 4'd1 : state_q - 4'd2;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state; idle-time values are forced to zero.
    always_comb begin
        cpu_select_out   = copy ? k_q : '0;
        mem_req_out      = ireq || dreq;
        mem_select_out   = dreq;
        mem_raddress_out = (ireq || dreq) ? base + MEMORY_ADDRESS_WIDTH'(k_q) : '0;
        aux_we_out       = copy || iwr || dwr;
        aux_waddress_out = copy ? AUX_ADDRESS_WIDTH'(k_q) :
                           iwr  ? AUX_ADDRESS_WIDTH'(CPU_ELEMENTS) + AUX_ADDRESS_WIDTH'(k_q) :
                           dwr  ? AUX_ADDRESS_WIDTH'(CPU_ELEMENTS + MEMORY_ELEMENTS) + AUX_ADDRESS_WIDTH'(k_q) :
                           '0;
        aux_wdata_out    = copy ? cpu_data_in : (iwr || dwr) ? word_q : '0;
        busy_out         = state_q != S_IDLE;
        done_out         = state_q == S_DONE;
    end

    // State registers with synchronous reset back to an idle, all-zero controller.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            pc_q    <= '0;
            daddr_q <= '0;
            ibase_q <= '0;
            dbase_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            pc_q    <= pc_d;
            daddr_q <= daddr_d;
            ibase_q <= ibase_d;
            dbase_q <= dbase_d;
            word_q  <= word_d;
        end
    end
endmodule

// File: tb/tb_aux_snapshot_controller.sv
// tb_aux_snapshot_controller: scoreboard bench for the aux snapshot sequencer.
module tb_aux_snapshot_controller;
    logic        clock_in = 1'b0;
    logic        reset_in, frame_start_in, mem_grant_in;
    logic [3:0]  cpu_select_out;
    logic [15:0] cpu_data_in, mem_data_in, aux_wdata_out;
    logic        mem_req_out, mem_select_out, aux_we_out, busy_out, done_out;
    logic [10:0] mem_raddress_out;
    logic [4:0]  aux_waddress_out;
`ifdef AUX_SNAPSHOT_HOLD_EN
    logic        hold_in;
`endif

    typedef struct {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;
    typedef struct {
        logic [15:0] pc;
        logic [15:0] da;
        logic [10:0] ib;
        logic [10:0] db;
    } vec_t;

    wr_t         exp_q[$];
    vec_t        vecs[6];
    logic [15:0] cpu_regs[16];
    int          checks, errors;

    aux_snapshot_controller dut (
        .clock_in(clock_in), .reset_in(reset_in), .frame_start_in(frame_start_in),
`ifdef AUX_SNAPSHOT_HOLD_EN
        .hold_in(hold_in),
`endif
        .cpu_select_out(cpu_select_out), .cpu_data_in(cpu_data_in),
        .mem_req_out(mem_req_out), .mem_grant_in(mem_grant_in),
        .mem_select_out(mem_select_out), .mem_raddress_out(mem_raddress_out),
        .mem_data_in(mem_data_in), .aux_we_out(aux_we_out),
        .aux_waddress_out(aux_waddress_out), .aux_wdata_out(aux_wdata_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    always #5 clock_in = ~clock_in;

    assign cpu_data_in = cpu_regs[cpu_select_out];

    always @(posedge clock_in)
        if (mem_req_out && mem_grant_in)
            mem_data_in <= {5'b0, mem_raddress_out} ^ (mem_select_out ? 16'hB000 : 16'hA000);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input logic [15:0] pc, input logic [15:0] da, input logic [10:0] ib,
                       input logic [10:0] db, input bit stall, input int extra,
                       input int rst_at, input int exp_done);
        int  done_rc = -1;
        int  dones = 0;
        wr_t w;
        for (int k = 0; k < 16; k++) cpu_regs[k] = 16'h1000 + 16'(k);
        cpu_regs[0] = pc;
        cpu_regs[2] = da;
        for (int k = 0; k < 10; k++) exp_q.push_back(wr_t'{5'(k), cpu_regs[k]});
        for (int i = 0; i < 10; i++) exp_q.push_back(wr_t'{5'(10 + i), {5'b0, ib + 11'(i)} ^ 16'hA000});
        for (int i = 0; i < 10; i++) exp_q.push_back(wr_t'{5'(20 + i), {5'b0, db + 11'(i)} ^ 16'hB000});
        for (int rc = 0; rc < 200; rc++) begin
            @(negedge clock_in);
            if (aux_we_out) begin
                if (exp_q.size() == 0) chk("aux extra write", int'(aux_waddress_out), -1);
                else begin
                    w = exp_q.pop_front();
                    chk("aux addr", int'(aux_waddress_out), int'(w.a));
                    chk("aux data", int'(aux_wdata_out), int'(w.d));
                end
            end
            if (stall && rc >= 18 && rc <= 25) begin
                chk("stall req", int'(mem_req_out), 1);
                chk("stall addr", int'(mem_raddress_out), int'(ib) + 2);
            end
            if (rc == 1) chk("busy after start", int'(busy_out), 1);
            if (done_out) begin
                dones++;
                if (done_rc < 0) done_rc = rc;
            end
            if (rst_at >= 0 && rc == rst_at + 1) begin
                chk("reset ctrl", int'({aux_we_out, mem_req_out, busy_out, done_out, mem_select_out}), 0);
                chk("reset sel", int'(cpu_select_out), 0);
                chk("reset raddr", int'(mem_raddress_out), 0);
                chk("reset waddr", int'(aux_waddress_out), 0);
                chk("reset wdata", int'(aux_wdata_out), 0);
            end
            if (done_rc >= 0 && rc == done_rc + 1) chk("idle after done", int'(busy_out), 0);
            frame_start_in = (rc == 0) || (rc == extra);
            mem_grant_in   = !(stall && rc >= 18 && rc <= 24);
            reset_in       = (rc == rst_at);
            if ((done_rc >= 0 && rc >= done_rc + 2) || (rst_at >= 0 && rc >= rst_at + 2)) break;
        end
        if (rst_at >= 0) chk("done during reset run", dones, 0);
        else begin
            chk("done cycle", done_rc, exp_done);
            chk("done count", dones, 1);
            chk("pending writes", exp_q.size(), 0);
        end
        exp_q.delete();
        frame_start_in = 1'b0;
        reset_in       = 1'b0;
        mem_grant_in   = 1'b1;
    endtask

    initial begin
        vecs[0] = '{16'h0003, 16'h0100, 11'h000, 11'h0FC};
        vecs[1] = '{16'h07FE, 16'h1000, 11'h7F6, 11'h7F6};
        vecs[2] = '{16'h0004, 16'h0005, 11'h000, 11'h001};
        vecs[3] = '{16'h0005, 16'h07FB, 11'h001, 11'h7F6};
        vecs[4] = '{16'h07FA, 16'h0009, 11'h7F6, 11'h005};
        vecs[5] = '{16'h8004, 16'hFFFF, 11'h7F6, 11'h7F6};
        checks = 0;
        errors = 0;
        reset_in = 1'b1;
        frame_start_in = 1'b0;
        mem_grant_in = 1'b1;
`ifdef AUX_SNAPSHOT_HOLD_EN
        hold_in = 1'b0;
`endif
        for (int k = 0; k < 16; k++) cpu_regs[k] = '0;
        repeat (3) @(negedge clock_in);
        chk("reset ctrl", int'({aux_we_out, mem_req_out, busy_out, done_out, mem_select_out}), 0);
        chk("reset sel", int'(cpu_select_out), 0);
        chk("reset raddr", int'(mem_raddress_out), 0);
        chk("reset waddr", int'(aux_waddress_out), 0);
        chk("reset wdata", int'(aux_wdata_out), 0);
        reset_in = 1'b0;
        foreach (vecs[i]) run(vecs[i].pc, vecs[i].da, vecs[i].ib, vecs[i].db, 1'b0, -1, -1, 72);
        run(16'h0003, 16'h0100, 11'h000, 11'h0FC, 1'b1, -1, -1, 79);
        run(16'h0003, 16'h0100, 11'h000, 11'h0FC, 1'b0, 30, -1, 72);
        run(16'h0200, 16'h0300, 11'h1FC, 11'h2FC, 1'b0, -1, 40, 72);
        run(16'h0200, 16'h0300, 11'h1FC, 11'h2FC, 1'b0, -1, -1, 72);
`ifdef AUX_SNAPSHOT_HOLD_EN
        hold_in = 1'b1;
        @(negedge clock_in);
        frame_start_in = 1'b1;
        @(negedge clock_in);
        frame_start_in = 1'b0;
        repeat (3) begin
            @(negedge clock_in);
            chk("hold busy", int'(busy_out), 0);
        end
        hold_in = 1'b0;
        run(16'h0003, 16'h0100, 11'h000, 11'h0FC, 1'b0, -1, -1, 72);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
